// File: rtl/seg7_msg_sequencer_pkg.sv
// Shared types and widths for the 7-segment message sequencer.
package seg7_seq_pkg;

  localparam int unsigned PRESC_W = 24;
  localparam int unsigned RATE_W  = 2;
  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    GAP   = 2'd3
  } seq_state_t;

  // Index where a pass begins for the given direction.
  function automatic logic [DIGIT_W-1:0] seq_first(input logic rev, input int unsigned len);
    return rev ? DIGIT_W'(len - 1) : '0;
  endfunction

  // Index where a pass ends for the given direction.
  function automatic logic [DIGIT_W-1:0] seq_last(input logic rev, input int unsigned len);
    return rev ? '0 : DIGIT_W'(len - 1);
  endfunction

endpackage

// File: rtl/seg7_msg_sequencer_btn.sv
// Rising-edge detector for one control input.
// With SEQ_DEBOUNCE_EN defined, the input is first synchronised (2 FF) and
// debounced (DEB_CYCLES consecutive equal samples) before edge detection.
module seg7_seq_btn #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_in,
  output logic o_edge
);

  logic r_prev;
  logic w_level;

`ifdef SEQ_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_deb_cnt;

  // Two-stage synchroniser; resets high so a held input gives no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_in;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level   <= 1'b1;
      r_deb_cnt <= '0;
    end else if (r_sync2 == r_level) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
      r_level   <= r_sync2;
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  assign w_level = r_level;
`else
  assign w_level = i_in;
`endif

  // Previous-sample flop for edge detection; resets high.
  always_ff @(posedge clk) begin
    if (reset) r_prev <= 1'b1;
    else       r_prev <= w_level;
  end

  assign o_edge = w_level & ~r_prev;

endmodule

// File: rtl/seg7_msg_sequencer.sv
// 7-segment message sequencer: start/stop/step control, direction, looping
// with blank gap, and selectable speed. Optional input debouncing is
// enabled by defining SEQ_DEBOUNCE_EN.
module seg7_msg_sequencer
  import seg7_seq_pkg::*;
#(
  parameter logic [PRESC_W-1:0] TICK_DIV    = 24'd10_000_000,
  parameter int unsigned        MSG_LEN     = 16,
  parameter int unsigned        BLANK_TICKS = 2,
  parameter int unsigned        DEB_CYCLES  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic              dir,
  input  logic              loop,
  input  logic [RATE_W-1:0] rate,
  output logic [DIGIT_W-1:0] digit,
  output logic              blank,
  output logic              tick,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state
);

  logic w_start, w_stop, w_step;

  seg7_seq_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_start (
    .clk(clk), .reset(reset), .i_in(start), .o_edge(w_start)
  );
  seg7_seq_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_stop (
    .clk(clk), .reset(reset), .i_in(stop), .o_edge(w_stop)
  );
  seg7_seq_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_step (
    .clk(clk), .reset(reset), .i_in(step), .o_edge(w_step)
  );

  seq_state_t         r_state, w_nxt_state;
  logic [DIGIT_W-1:0] r_digit, w_nxt_digit;
  logic               r_blank, w_nxt_blank;
  logic               r_tick,  w_nxt_tick;
  logic               r_busy,  w_nxt_busy;
  logic               r_done,  w_nxt_done;
  logic [PRESC_W-1:0] r_cnt,   w_nxt_cnt;
  logic [7:0]         r_gap,   w_nxt_gap;

  logic [PRESC_W-1:0] w_period;
  logic [PRESC_W-1:0] w_limit;
  logic               w_running;
  logic               w_itick;
  logic [DIGIT_W-1:0] w_first;
  logic [DIGIT_W-1:0] w_last;
  logic [DIGIT_W-1:0] w_adv;

  assign w_period  = TICK_DIV >> rate;
  assign w_limit   = (w_period == '0) ? '0 : w_period - 1'b1;
  assign w_running = (r_state == RUN) || (r_state == GAP);
  assign w_itick   = w_running && (r_cnt >= w_limit);
  assign w_first   = seq_first(dir, MSG_LEN);
  assign w_last    = seq_last(dir, MSG_LEN);
  assign w_adv     = dir ? r_digit - 1'b1 : r_digit + 1'b1;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_digit <= '0;
      r_blank <= 1'b1;
      r_tick  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_digit <= w_nxt_digit;
      r_blank <= w_nxt_blank;
      r_tick  <= w_nxt_tick;
      r_busy  <= w_nxt_busy;
      r_done  <= w_nxt_done;
      r_cnt   <= w_nxt_cnt;
      r_gap   <= w_nxt_gap;
    end
  end

  // Next-state, next-output and prescaler logic; start > stop > step > tick.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_digit = r_digit;
    w_nxt_blank = r_blank;
    w_nxt_tick  = 1'b0;
    w_nxt_done  = 1'b0;
    w_nxt_gap   = r_gap;

    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          w_nxt_state = RUN;
          w_nxt_digit = w_first;
          w_nxt_blank = 1'b0;
        end
      end
      RUN: begin
        if (w_start) begin
          w_nxt_digit = w_first;
          w_nxt_blank = 1'b0;
        end else if (w_stop) begin
          w_nxt_state = PAUSE;
        end else if (w_step) begin
          // step has no action while running but still outranks the tick
        end else if (w_itick) begin
          if (r_digit != w_last) begin
            w_nxt_digit = w_adv;
            w_nxt_tick  = 1'b1;
          end else if (loop) begin
            if (BLANK_TICKS == 0) begin
              w_nxt_digit = w_first;
              w_nxt_tick  = 1'b1;
            end else begin
              w_nxt_state = GAP;
              w_nxt_blank = 1'b1;
              w_nxt_gap   = '0;
            end
          end else begin
            w_nxt_state = IDLE;
            w_nxt_blank = 1'b1;
            w_nxt_done  = 1'b1;
          end
        end
      end
      GAP: begin
        if (w_start) begin
          w_nxt_state = RUN;
          w_nxt_digit = w_first;
          w_nxt_blank = 1'b0;
        end else if (w_stop) begin
          w_nxt_state = PAUSE;
          w_nxt_digit = w_first;
          w_nxt_blank = 1'b0;
        end else if (w_step) begin
          // dropped tick, as in RUN
        end else if (w_itick) begin
          if (32'(r_gap) + 32'd1 >= BLANK_TICKS) begin
            w_nxt_state = RUN;
            w_nxt_digit = w_first;
            w_nxt_blank = 1'b0;
            w_nxt_tick  = 1'b1;
          end else begin
            w_nxt_gap = r_gap + 8'd1;
          end
        end
      end
      PAUSE: begin
        w_nxt_blank = 1'b0;
        if (w_start) begin
          w_nxt_state = RUN;
        end else if (w_stop) begin
          // already paused; swallows a same-cycle step
        end else if (w_step) begin
          if (r_digit != w_last) begin
            w_nxt_digit = w_adv;
            w_nxt_tick  = 1'b1;
          end else if (loop) begin
            w_nxt_digit = w_first;
            w_nxt_tick  = 1'b1;
          end
        end
      end
      default: w_nxt_state = IDLE;
    endcase

    w_nxt_cnt = w_running ? (w_itick ? '0 : r_cnt + 1'b1) : '0;
    if ((w_nxt_state != r_state) || w_start) w_nxt_cnt = '0;
    w_nxt_busy = (w_nxt_state == RUN) || (w_nxt_state == GAP);
  end

  assign digit = r_digit;
  assign blank = r_blank;
  assign tick  = r_tick;
  assign busy  = r_busy;
  assign done  = r_done;
  assign state = r_state;

endmodule

// File: doc/seg7_msg_sequencer.md
Name: seg7_msg_sequencer

Overview:
Controller that sequences the 16-entry 7-segment message display. It replaces the free-running second counter and digit counter with start, stop and single-step control, forward or reverse direction, one-shot or looping playback, and selectable speed. Its outputs drive the existing seg7 decoder index and blanking.

Parameters:
TICK_DIV, 24'd10_000_000, base prescaler period in clk cycles (one step per second at 10 MHz)
MSG_LEN, 16, number of message entries; legal range 2..16
BLANK_TICKS, 2, blank ticks inserted between loops; 0 means no gap
DEB_CYCLES, 16, debounce stable-sample count (used only with SEQ_DEBOUNCE_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  rising edge starts from the first index, or resumes from PAUSE
stop  in  1  rising edge pauses playback
step  in  1  rising edge advances one index while in PAUSE
dir  in  1  level; 0 = forward (0→MSG_LEN-1), 1 = reverse
loop  in  1  level; 1 = wrap through GAP, 0 = one-shot
rate  in  2  speed select; period P = TICK_DIV >> rate
digit  out  4  decoder index; always ≤ MSG_LEN-1
blank  out  1  1 = display off
tick  out  1  one-cycle pulse on each index advance
busy  out  1  1 while in RUN or GAP
done  out  1  one-cycle pulse when a one-shot pass completes
state  out  2  FSM state, for debug

Behaviour:
- All outputs are registered.
- Reset values: digit=0, blank=1, tick=0, busy=0, done=0, state=IDLE. Prescaler=0, gap counter=0.
- Edge-detect flops reset to 1, so an input held high through reset does not produce an edge.
- Edge = in & ~prev. Without the macro, an edge sampled at cycle n is acted on in the outputs at cycle n+1.
- Command priority in every state: start > stop > step > tick. A lower-priority event in the same cycle is dropped.
- First index F = dir ? MSG_LEN-1 : 0. Last index L = dir ? 0 : MSG_LEN-1. dir is sampled at each advance.
- Prescaler is a 24-bit counter and runs only in RUN and GAP.
  - Internal tick fires when cnt >= P-1, then cnt clears.
  - The >= compare means a rate change mid-count that leaves cnt past the new limit fires on the next cycle.
  - cnt clears on every state change.
- IDLE: blank=1. start edge → RUN, digit=F, blank=0.
- RUN:
  - Tick with digit≠L: digit steps ±1 and the tick output pulses.
  - Tick with digit=L and loop=1: → GAP (blank=1, gap count=0), or directly to digit=F if BLANK_TICKS=0.
  - Tick with digit=L and loop=0: → IDLE, done=1 for one cycle, digit holds L, blank=1.
  - stop edge → PAUSE. start edge → restart at F.
- GAP: counts ticks. After BLANK_TICKS ticks → RUN, digit=F, blank=0. stop edge → PAUSE, digit=F, blank=0.
- PAUSE:
  - Prescaler held at 0, blank=0.
  - step edge: advance one index. At L with loop=1, wrap to F (no gap). At L with loop=0, hold and emit no done.
  - start edge → RUN; the prescaler restarts from 0.
- Reset asserted in any state returns to the reset values on the next clock.

Optional Feature:
SEQ_DEBOUNCE_EN:
- Defined: start, stop and step each pass through a 2-FF synchronizer, then a debouncer that accepts a new level only after DEB_CYCLES consecutive equal samples. Edge detection runs on the debounced level.
  - Command latency = 2 + DEB_CYCLES + 1 cycles.
  - Pulses shorter than DEB_CYCLES are ignored.
- Undefined: no synchronizer or debouncer; edges are detected on the raw inputs with 1-cycle latency. dir, loop and rate are used unsynchronized in both builds.

Decomposition:
- Package seg7_seq_pkg holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, GAP=2'd3
  - PRESC_W=24, RATE_W=2, DIGIT_W=4
- One sub-module, seg7_seq_btn: edge detector with the optional sync/debounce, instantiated three times (start, stop, step). The FSM and prescaler stay in the top module.

Test Plan:
- TICK_DIV=8, rate=0, loop=0, dir=0; pulse start → digit steps 0,1,…,15 every 8 cycles; done pulses once; returns to IDLE with blank=1 and digit=15.
- loop=1, BLANK_TICKS=2, rate=1 (P=4) → after digit 15, blank=1 for 8 cycles, then digit=0 and blank=0; busy stays 1 throughout.
- dir=1 → start gives digit=15, then 14, …, 0. Flip dir mid-run at digit=9 → the next tick gives digit=10.
- Start then stop, issue 3 step pulses from digit=4 → digit=5,6,7, no internal tick; the tick output pulses per step. Then start → resume, first advance 8 cycles later.
- start and stop asserted in the same cycle from PAUSE → RUN. reset asserted mid-RUN at digit=6 → next cycle all outputs are at reset values. start held high through reset → no start action.
- With SEQ_DEBOUNCE_EN, DEB_CYCLES=16: a 10-cycle start glitch is ignored; a 20-cycle pulse starts playback exactly 19 cycles after the rising edge.
